action_irq_ctrl: RTL
====================

# action_irq_ctrl

Parametrised interrupt and control-register sideband for HLS action wrappers. It serves NUM_IRQ level interrupt lines from one or more HLS kernels, arbitrating them round-robin onto the single host interrupt/ack handshake. Each line has its own 64-bit source address, and one context ID register is shared. It also returns read data for the wrapper-owned registers (ACTION_TYPE, RELEASE_LEVEL, status), which the wrapper ORs into the kernel's s_axi_ctrl_reg_rdata. It sits between the HLS kernel(s) and the action_wrapper ports.

## Interface
Parameters:
- NUM_IRQ, 4: number of kernel interrupt lines, 1..16.
- CTXW, 9: context ID width.
- ACTION_TYPE, 32'h10143009: value returned at BASE+0x10.
- RELEASE_LEVEL, 32'h00000001: value returned at BASE+0x14.
- BASE_ADDR, 32'h10000: base of the wrapper-owned register window.
- ACK_TIMEOUT, 1024: WAIT_ACK retry threshold in cycles (used only with the macro defined).

Ports:
- Clock is clk; reset is resetn, synchronous, active-low.
- irq_in, in, NUM_IRQ: kernel interrupt levels; a rising edge requests service.
- interrupt, out, 1: one-cycle request pulse to the host.
- interrupt_src, out, 64: source address of the line being served.
- interrupt_ctx, out, CTXW: context ID.
- interrupt_ack, in, 1: host acknowledge pulse.
- reg_wr_valid, in, 1: control-register write strobe (wvalid & wready).
- reg_wr_addr, in, 32: write address.
- reg_wr_data, in, 32: write data.
- reg_rd_valid, in, 1: read-address strobe (arvalid & arready).
- reg_rd_addr, in, 32: read address.
- reg_rd_data, out, 32: hijack read data, ORed by the wrapper into s_axi_ctrl_reg_rdata.
- irq_busy, out, 1: FSM is not IDLE.

## Operation
Register map (offsets from BASE_ADDR):
- 0x00 CTX, RW: holds the context ID in bits [CTXW-1:0].
- 0x04 STATUS, RO: bits [15:0] are the pending bits, bit 31 is the sticky timeout flag, bit 30 is busy. Reading STATUS clears bit 31.
- 0x08 ENABLE, RW: per-line enable mask, reset value all-ones.
- 0x10 ACTION_TYPE, RO.
- 0x14 RELEASE_LEVEL, RO.
- 0x18+8*i SRC_LO[i] and 0x1C+8*i SRC_HI[i], RW.

Writes to RO or unmapped addresses are ignored. Reads of unmapped addresses return 0.

Edge capture and pending:
- irq_in is registered. A rising edge on an enabled line sets pending[i].
- Edges on disabled lines are dropped.
- Repeated edges while pending[i] is set merge into a single request.

FSM states IDLE, ISSUE, WAIT_ACK:
- IDLE → ISSUE when any pending bit is set. The arbiter grants the first pending line after last_grant (round-robin), clears that pending bit, latches interrupt_src = {SRC_HI, SRC_LO} for that line, and updates last_grant.
- ISSUE → WAIT_ACK unconditionally. interrupt = 1 only while in ISSUE.
- WAIT_ACK → IDLE on interrupt_ack.
- An ack seen in IDLE or in ISSUE is ignored.

Boundary conditions:
- An edge on the line being served, arriving during ISSUE or WAIT_ACK, sets pending again. That line is served again only after the other pending lines, per round-robin order.
- A same-cycle edge and grant on the same line leaves pending set.
- A SRC write during ISSUE or WAIT_ACK does not change the latched interrupt_src.
- Clearing an ENABLE bit also clears that line's pending bit. It does not abort a line already in service.
- Reset mid-operation returns the FSM to IDLE and clears pending, the timeout flag and the irq_in history register.
- Reset values: interrupt = 0, interrupt_src = 0, interrupt_ctx = 0, reg_rd_data = 0, irq_busy = 0, last_grant = NUM_IRQ-1 (so line 0 wins first).

## Timing
- Rising edge sampled at cycle n → pending set at n+1 → interrupt high at cycle n+2, for exactly one cycle.
- Minimum interrupt spacing: the ack cycle, then IDLE for one cycle, then ISSUE. This gives 2 cycles from ack to the next pulse.
- reg_rd_data is registered: valid the cycle after reg_rd_valid and held until the next reg_rd_valid. It is 0 for addresses the kernel owns.
- A register write takes effect the cycle after reg_wr_valid.

## Configuration
- ACTION_IRQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_ACK.
  - When it reaches ACK_TIMEOUT without an ack, the FSM returns to ISSUE, re-pulses interrupt with the same latched interrupt_src, sets STATUS[31], and restarts the count.
- ACTION_IRQ_TIMEOUT_EN undefined: no counter; WAIT_ACK waits indefinitely, and STATUS[31] reads 0.

## Test plan
- Reset, then read BASE+0x10 and BASE+0x14 → reg_rd_data = 32'h10143009 and 32'h00000001 one cycle later. Read of unmapped BASE+0x40 → 0.
- Write SRC_LO[2]=0xCAFE0000 and SRC_HI[2]=0x1; raise irq_in[2] → interrupt pulses once 2 cycles later with interrupt_src = 64'h1_CAFE0000. Ack → irq_busy falls.
- Raise irq_in[0,1,3] in the same cycle → three pulses in order 0, 1, 3, each issued only after the previous ack.
- Toggle irq_in[1] twice while line 1 is in WAIT_ACK → exactly one further pulse for line 1. Ack pulsed during ISSUE → ignored, so the FSM still waits for a later ack.
- ENABLE = 4'b1110, edge on line 0 → no pulse, STATUS[0] = 0. Write CTX = 9'h1A5 → interrupt_ctx = 9'h1A5.
- With ACTION_IRQ_TIMEOUT_EN and ACK_TIMEOUT = 16: no ack → re-pulse 17 cycles after the first pulse, STATUS[31] = 1. Reading STATUS clears bit 31. Without the macro, no re-pulse occurs within 2000 cycles.

Source files
------------

// File: rtl/action_irq_ctrl_if.sv
// Sideband bundle between the HLS kernel(s), action_irq_ctrl and the action wrapper:
// kernel interrupt levels, host interrupt/ack handshake and control-register hijack strobes.
interface action_irq_ctrl_if #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned CTXW    = 9
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               interrupt;
    logic [63:0]        interrupt_src;
    logic [CTXW-1:0]    interrupt_ctx;
    logic               interrupt_ack;
    logic               reg_wr_valid;
    logic [31:0]        reg_wr_addr;
    logic [31:0]        reg_wr_data;
    logic               reg_rd_valid;
    logic [31:0]        reg_rd_addr;
    logic [31:0]        reg_rd_data;
    logic               irq_busy;

    modport slave (
        input  irq_in, interrupt_ack,
        input  reg_wr_valid, reg_wr_addr, reg_wr_data,
        input  reg_rd_valid, reg_rd_addr,
        output interrupt, interrupt_src, interrupt_ctx,
        output reg_rd_data, irq_busy
    );

    modport master (
        output irq_in, interrupt_ack,
        output reg_wr_valid, reg_wr_addr, reg_wr_data,
        output reg_rd_valid, reg_rd_addr,
        input  interrupt, interrupt_src, interrupt_ctx,
        input  reg_rd_data, irq_busy
    );
endinterface

// File: rtl/action_irq_ctrl.sv
// Round-robin interrupt arbiter and wrapper-owned register window for HLS actions.
// Optional ack-timeout re-issue is enabled by defining ACTION_IRQ_TIMEOUT_EN.
module action_irq_ctrl #(
    parameter int unsigned NUM_IRQ       = 4,
    parameter int unsigned CTXW          = 9,
    parameter logic [31:0] ACTION_TYPE   = 32'h10143009,
    parameter logic [31:0] RELEASE_LEVEL = 32'h00000001,
    parameter logic [31:0] BASE_ADDR     = 32'h00010000,
    parameter int unsigned ACK_TIMEOUT   = 1024
) (
    input  logic            clk,
    input  logic            resetn,
    action_irq_ctrl_if.slave bus
);
    localparam int unsigned IDXW    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] WIN_END = 32'h00000018 + 32'(8 * NUM_IRQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] enable_d;
    logic [NUM_IRQ-1:0] edge_s;
    logic [NUM_IRQ-1:0] grant_mask_s;
    logic [IDXW-1:0]    last_grant_q;
    logic [IDXW-1:0]    grant_idx_s;
    logic               grant_vld_s;
    logic               interrupt_q;
    logic               busy_q;
    logic [63:0]        src_q;
    logic [CTXW-1:0]    ctx_q;
    logic [31:0]        src_lo_q [NUM_IRQ];
    logic [31:0]        src_hi_q [NUM_IRQ];
    logic [31:0]        rd_data_q;
    logic [31:0]        rd_mux_s;
    logic [15:0]        pend16_s;
    logic               timeout_s;
    logic               to_flag_s;

    logic [31:0] wr_off_s, rd_off_s, wr_src_off_s, rd_src_off_s;
    logic        wr_hit_s, rd_in_win_s, status_rd_s;

    assign wr_off_s     = bus.reg_wr_addr - BASE_ADDR;
    assign rd_off_s     = bus.reg_rd_addr - BASE_ADDR;
    assign wr_src_off_s = wr_off_s - 32'h00000018;
    assign rd_src_off_s = rd_off_s - 32'h00000018;
    assign wr_hit_s     = bus.reg_wr_valid && (bus.reg_wr_addr >= BASE_ADDR) &&
                          (wr_off_s < WIN_END) && (wr_off_s[1:0] == 2'b00);
    assign rd_in_win_s  = (bus.reg_rd_addr >= BASE_ADDR) && (rd_off_s < WIN_END) &&
                          (rd_off_s[1:0] == 2'b00);
    assign status_rd_s  = bus.reg_rd_valid && rd_in_win_s && (rd_off_s == 32'h00000004);
    assign edge_s       = bus.irq_in & ~irq_q;

    // Round-robin search starting just after the last granted line.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = last_grant_q;
        for (int unsigned k = 1; k <= NUM_IRQ; k++) begin
            int unsigned cand;
            cand = 32'(last_grant_q) + k;
            if (cand >= NUM_IRQ) begin
                cand = cand - NUM_IRQ;
            end else begin
                cand = cand;
            end
            if (!grant_vld_s && pending_q[IDXW'(cand)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = IDXW'(cand);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Next enable mask and pending set; a new edge wins over a same-cycle grant clear.
    always_comb begin
        enable_d     = enable_q;
        grant_mask_s = '0;
        if (wr_hit_s && (wr_off_s == 32'h00000008)) begin
            enable_d = bus.reg_wr_data[NUM_IRQ-1:0];
        end else begin
            enable_d = enable_q;
        end
        if ((state_q == IDLE) && grant_vld_s) begin
            grant_mask_s[grant_idx_s] = 1'b1;
        end else begin
            grant_mask_s = '0;
        end
        pending_d = ((pending_q & ~grant_mask_s) | (edge_s & enable_q)) & enable_d;
    end

    // Serving FSM with registered pulse, busy and latched source address.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            last_grant_q <= IDXW'(NUM_IRQ - 1);
            interrupt_q  <= 1'b0;
            busy_q       <= 1'b0;
            src_q        <= 64'h0;
        end else begin
            irq_q     <= bus.irq_in;
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (grant_vld_s) begin
                        state_q      <= ISSUE;
                        interrupt_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        src_q        <= {src_hi_q[grant_idx_s], src_lo_q[grant_idx_s]};
                        last_grant_q <= grant_idx_s;
                    end else begin
                        interrupt_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_q     <= WAIT_ACK;
                    interrupt_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
                WAIT_ACK: begin
                    if (bus.interrupt_ack) begin
                        state_q     <= IDLE;
                        interrupt_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (timeout_s) begin
                        state_q     <= ISSUE;
                        interrupt_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        interrupt_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    interrupt_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACTION_IRQ_TIMEOUT_EN
    localparam int unsigned CNTW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [CNTW-1:0] to_cnt_q;
    logic            to_flag_q;

    assign timeout_s = (state_q == WAIT_ACK) && !bus.interrupt_ack &&
                       (to_cnt_q == CNTW'(ACK_TIMEOUT - 1));
    assign to_flag_s = to_flag_q;

    // Ack-wait counter and sticky timeout flag; a fresh timeout beats a STATUS read clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if ((state_q == WAIT_ACK) && !bus.interrupt_ack && !timeout_s) begin
                to_cnt_q <= to_cnt_q + CNTW'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (timeout_s) begin
                to_flag_q <= 1'b1;
            end else if (status_rd_s) begin
                to_flag_q <= 1'b0;
            end else begin
                to_flag_q <= to_flag_q;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign to_flag_s = 1'b0;
`endif

    // Wrapper-owned register writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctx_q    <= '0;
            enable_q <= '1;
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                src_lo_q[i] <= 32'h0;
                src_hi_q[i] <= 32'h0;
            end
        end else begin
            enable_q <= enable_d;
            if (wr_hit_s && (wr_off_s == 32'h00000000)) begin
                ctx_q <= bus.reg_wr_data[CTXW-1:0];
            end
            if (wr_hit_s && (wr_off_s >= 32'h00000018)) begin
                if (wr_src_off_s[2]) begin
                    src_hi_q[wr_src_off_s[IDXW+2:3]] <= bus.reg_wr_data;
                end else begin
                    src_lo_q[wr_src_off_s[IDXW+2:3]] <= bus.reg_wr_data;
                end
            end
        end
    end

    // Read mux; anything outside the window belongs to the kernel and reads as zero.
    always_comb begin
        rd_mux_s = 32'h0;
        pend16_s = 16'h0;
        pend16_s[NUM_IRQ-1:0] = pending_q;
        if (rd_in_win_s) begin
            if (rd_off_s == 32'h00000000) begin
                rd_mux_s[CTXW-1:0] = ctx_q;
            end else if (rd_off_s == 32'h00000004) begin
                rd_mux_s = {to_flag_s, busy_q, 14'h0, pend16_s};
            end else if (rd_off_s == 32'h00000008) begin
                rd_mux_s[NUM_IRQ-1:0] = enable_q;
            end else if (rd_off_s == 32'h00000010) begin
                rd_mux_s = ACTION_TYPE;
            end else if (rd_off_s == 32'h00000014) begin
                rd_mux_s = RELEASE_LEVEL;
            end else if (rd_off_s >= 32'h00000018) begin
                rd_mux_s = rd_src_off_s[2] ? src_hi_q[rd_src_off_s[IDXW+2:3]]
                                           : src_lo_q[rd_src_off_s[IDXW+2:3]];
            end else begin
                rd_mux_s = 32'h0;
            end
        end else begin
            rd_mux_s = 32'h0;
        end
    end

    // Read data is held until the next read strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data_q <= 32'h0;
        end else if (bus.reg_rd_valid) begin
            rd_data_q <= rd_mux_s;
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign bus.interrupt     = interrupt_q;
    assign bus.interrupt_src = src_q;
    assign bus.interrupt_ctx = ctx_q;
    assign bus.reg_rd_data   = rd_data_q;
    assign bus.irq_busy      = busy_q;
endmodule
